// File: rtl/burst_adapter.sv
// rtl/burst_adapter.sv - whole-cacheline to fixed-length memory burst adapter
// One line transaction in flight; reads gather beats, writes split a latched line.
module burst_adapter #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [ADDR_WIDTH-1:0] line_address_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  line_resp_o,
  input  logic [BURST_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_resp_i,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [BURST_WIDTH-1:0] mem_wdata_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o
);

  localparam int BEATS = LINE_WIDTH / BURST_WIDTH;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]                        state;
  logic [CW-1:0]                     count;
  logic [ADDR_WIDTH-1:0]             addr_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] rbuf;
  logic [BEATS-1:0][BURST_WIDTH-1:0] wbuf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      addr_q <= '0;
      rbuf   <= '0;
      wbuf   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when both requests arrive together.
          if (line_write_i) begin
            addr_q <= line_address_i;
            wbuf   <= line_wdata_i;
            count  <= '0;
            state  <= WRITE;
          end else if (line_read_i) begin
            addr_q <= line_address_i;
            count  <= '0;
            state  <= READ;
          end
        end
        READ: begin
          if (mem_resp_i) begin
            rbuf[count] <= mem_rdata_i;
            if (count == LAST_BEAT) state <= DONE;
            else count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (mem_resp_i) begin
            if (count == LAST_BEAT) state <= DONE;
            else count <= count + 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decodes only; nothing from the line side reaches these outputs.
  assign mem_read_o    = (state == READ);
  assign mem_write_o   = (state == WRITE);
  assign line_resp_o   = (state == DONE);
  assign mem_wdata_o   = (state == WRITE) ? wbuf[count] : '0;
  assign mem_address_o = addr_q;
  assign line_rdata_o  = rbuf;

endmodule

// File: tb/tb_burst_adapter.sv
// tb/tb_burst_adapter.sv - scoreboard bench for burst_adapter
`timescale 1ns/1ps
module tb_burst_adapter;

  logic         clk;
  logic         rst;
  logic         line_read_i;
  logic         line_write_i;
  logic [31:0]  line_address_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [63:0]  mem_wdata_o;
  logic [31:0]  mem_address_o;

  burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_read_i(line_read_i), .line_write_i(line_write_i),
    .line_address_i(line_address_i), .line_wdata_i(line_wdata_i),
    .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
    .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_wdata_o(mem_wdata_o), .mem_address_o(mem_address_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           is_read;
    logic [255:0] line;
    time          t;
    string        name;
  } exp_t;

  exp_t         q[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [255:0] last_line;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every line_resp_o must match the oldest pending expectation.
  always @(negedge clk) begin
    if (line_resp_o) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_resp: got line_resp_o=1 at %0t expected none", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_time"}, 256'($time), 256'(e.t));
        if (e.is_read) chk({e.name, "_data"}, line_rdata_o, e.line);
      end
    end
  end

  // Caller sits 1ns after a rising edge with the DUT idle; returns likewise.
  task automatic do_read(input logic [31:0] addr, input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3, input int gap,
                         input string name);
    logic [63:0] bt[4];
    time e0;
    bt[0] = b0; bt[1] = b1; bt[2] = b2; bt[3] = b3;
    chk({name, "_idle_rd"}, 256'(mem_read_o), 256'(0));
    line_read_i    = 1'b1;
    line_address_i = addr;
    e0 = $time + 9;
    last_line = {b3, b2, b1, b0};
    q.push_back('{1'b1, last_line, e0 + 10 * (4 + gap * 3) + 5, name});
    @(posedge clk); #1;
    line_address_i = ~addr;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        for (int g = 0; g < gap; g++) begin
          mem_resp_i  = 1'b0;
          mem_rdata_i = 64'hBAD0_BAD0_BAD0_BAD0;
          chk({name, "_gap_rd"}, 256'(mem_read_o), 256'(1));
          chk({name, "_gap_addr"}, 256'(mem_address_o), 256'(addr));
          @(posedge clk); #1;
        end
      end
      mem_resp_i  = 1'b1;
      mem_rdata_i = bt[b];
      chk({name, "_rd"}, 256'(mem_read_o), 256'(1));
      chk({name, "_wr"}, 256'(mem_write_o), 256'(0));
      chk({name, "_addr"}, 256'(mem_address_o), 256'(addr));
      @(posedge clk); #1;
    end
    mem_resp_i = 1'b0;
    chk({name, "_rd_drop"}, 256'(mem_read_o), 256'(0));
    chk({name, "_done_addr"}, 256'(mem_address_o), 256'(addr));
    @(posedge clk); #1;
    line_read_i = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input int gap,
                          input bit both, input string name);
    logic [63:0] bt[4];
    time e0;
    for (int b = 0; b < 4; b++) bt[b] = line[b*64 +: 64];
    chk({name, "_idle_wr"}, 256'(mem_write_o), 256'(0));
    line_write_i   = 1'b1;
    line_read_i    = both;
    line_address_i = addr;
    line_wdata_i   = line;
    e0 = $time + 9;
    q.push_back('{1'b0, '0, e0 + 10 * (4 + gap * 4) + 5, name});
    @(posedge clk); #1;
    line_address_i = ~addr;
    line_wdata_i   = ~line;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < gap; g++) begin
        mem_resp_i = 1'b0;
        chk({name, "_gap_wdata"}, 256'(mem_wdata_o), 256'(bt[b]));
        chk({name, "_gap_wr"}, 256'(mem_write_o), 256'(1));
        @(posedge clk); #1;
      end
      mem_resp_i = 1'b1;
      chk({name, "_wdata"}, 256'(mem_wdata_o), 256'(bt[b]));
      chk({name, "_wr"}, 256'(mem_write_o), 256'(1));
      chk({name, "_no_rd"}, 256'(mem_read_o), 256'(0));
      chk({name, "_addr"}, 256'(mem_address_o), 256'(addr));
      @(posedge clk); #1;
    end
    mem_resp_i = 1'b0;
    chk({name, "_wr_drop"}, 256'(mem_write_o), 256'(0));
    @(posedge clk); #1;
    line_write_i = 1'b0;
    line_read_i  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] wline;
    rst = 1'b1; line_read_i = 1'b0; line_write_i = 1'b0;
    line_address_i = '0; line_wdata_i = '0; mem_rdata_i = '0; mem_resp_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", line_rdata_o, '0);
    chk("rst_resp", 256'(line_resp_o), 256'(0));
    chk("rst_mem_rd", 256'(mem_read_o), 256'(0));
    chk("rst_mem_wr", 256'(mem_write_o), 256'(0));
    chk("rst_wdata", 256'(mem_wdata_o), 256'(0));
    chk("rst_addr", 256'(mem_address_o), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    do_read(32'h0000_2000, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 0, "rd_consec");
    do_read(32'h0000_2040, 64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
            64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD, 2, "rd_gap2");

    wline = {64'hDEAD_0123_4567_89AB, 64'hCDEF_0011_2233_4455,
             64'h6677_8899_AABB_CCDD, 64'hEEFF_0102_0304_BEEF};
    do_write(32'h0000_1000, wline, 1, 1'b0, "wr_line");

    wline = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0,
             64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
    do_write(32'h0000_3000, wline, 0, 1'b1, "wr_both");
    do_read(32'h0000_3000, 64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
            64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888, 0, "rd_after_wr");

    // Stray memory response while idle must not disturb anything.
    mem_rdata_i = '1;
    mem_resp_i  = 1'b1;
    @(posedge clk); #1;
    mem_resp_i  = 1'b0;
    chk("idle_resp_rdata", line_rdata_o, last_line);
    chk("idle_resp_rd", 256'(mem_read_o), 256'(0));
    chk("idle_resp_wr", 256'(mem_write_o), 256'(0));
    do_read(32'h0000_4000, 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
            64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404, 0, "rd_post_idle");

    // Abort a read after its third beat.
    line_read_i = 1'b1; line_address_i = 32'h0000_5000;
    @(posedge clk); #1;
    for (int b = 0; b < 3; b++) begin
      mem_resp_i  = 1'b1;
      mem_rdata_i = {16{4'(b + 9)}};
      @(posedge clk); #1;
    end
    mem_resp_i = 1'b0; line_read_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_rdata", line_rdata_o, '0);
    chk("abort_resp", 256'(line_resp_o), 256'(0));
    chk("abort_mem_rd", 256'(mem_read_o), 256'(0));
    chk("abort_mem_wr", 256'(mem_write_o), 256'(0));
    chk("abort_wdata", 256'(mem_wdata_o), 256'(0));
    chk("abort_addr", 256'(mem_address_o), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h0000_6000, 64'h9999_9999_9999_9999, 64'hEEEE_EEEE_EEEE_EEEE,
            64'h1357_9BDF_1357_9BDF, 64'h2468_ACE0_2468_ACE0, 1, "rd_post_rst");

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 256'(q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
